// File: rtl/core_sequencer_pkg.sv
// Shared core-level types: core FSM encodings, LSU state encodings, fetcher handshake value.
// Pure declarations; no timing of its own.
// The DECODE encoding is shared with the decoder, so the enum is pinned to CORE_DECODE.
package core_pkg;

  localparam logic [2:0]  CORE_DECODE     = 3'b010;
  localparam logic [2:0]  FETCHER_FETCHED = 3'b010;
  localparam logic [15:0] INSTR_COUNT_MAX = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b000,
    ST_FETCH   = 3'b001,
    ST_DECODE  = CORE_DECODE,
    ST_REQUEST = 3'b011,
    ST_WAIT    = 3'b100,
    ST_EXECUTE = 3'b101,
    ST_UPDATE  = 3'b110,
    ST_DONE    = 3'b111
  } core_state_e;

  typedef enum logic [1:0] {
    LSU_IDLE       = 2'b00,
    LSU_REQUESTING = 2'b01,
    LSU_WAITING    = 2'b10,
    LSU_DONE       = 2'b11
  } lsu_state_e;

  // An LSU holds the core in WAIT while it has a request outstanding.
  function automatic logic lsu_busy(input logic [1:0] s);
    return (s == LSU_REQUESTING) || (s == LSU_WAITING);
  endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// Bundle between the core sequencer and the per-thread datapath / dispatcher.
// master = sequencer side (drives core_state and status), slave = datapath side.
// No flow control of its own; all handshakes are level-based state buses.
interface core_sequencer_if #(
  parameter int THREADS = 4,
  parameter int PC_BITS = 8
);
  logic                       start;
  logic [THREADS-1:0]         thread_enable;
  logic [2:0]                 fetcher_state;
  logic                       decoded_mem_read_enable;
  logic                       decoded_mem_write_enable;
  logic                       decoded_ret;
  logic [2*THREADS-1:0]       lsu_state;
  logic [PC_BITS*THREADS-1:0] next_pc;
  logic [2:0]                 core_state;
  logic [PC_BITS-1:0]         current_pc;
  logic                       done;
  logic                       divergence;
  logic [15:0]                instr_count;

  modport master (
    input  start, thread_enable, fetcher_state, decoded_mem_read_enable,
           decoded_mem_write_enable, decoded_ret, lsu_state, next_pc,
    output core_state, current_pc, done, divergence, instr_count
  );

  modport slave (
    output start, thread_enable, fetcher_state, decoded_mem_read_enable,
           decoded_mem_write_enable, decoded_ret, lsu_state, next_pc,
    input  core_state, current_pc, done, divergence, instr_count
  );
endinterface

// File: rtl/core_sequencer_thread_pc_select.sv
// Picks the next shared PC from the lowest enabled thread and flags disagreement.
// Purely combinational, zero latency.
// No backpressure; result is consumed by the sequencer in UPDATE only.
module thread_pc_select #(
  parameter int THREADS = 4,
  parameter int PC_BITS = 8
) (
  input  logic [THREADS-1:0]         thread_enable,
  input  logic [PC_BITS*THREADS-1:0] next_pc,
  input  logic [PC_BITS-1:0]         current_pc,
  output logic [PC_BITS-1:0]         pc_sel,
  output logic                       diverged
);

  logic found;

  // Priority pick: lowest enabled thread wins; with no thread enabled the PC just steps by one.
  always_comb begin
    pc_sel = current_pc + 1'b1;
    found  = 1'b0;
    for (int i = 0; i < THREADS; i++) begin
      if (thread_enable[i] && !found) begin
        pc_sel = next_pc[PC_BITS*i +: PC_BITS];
        found  = 1'b1;
      end
    end
  end

  // Any enabled thread differing from the chosen one means at least two enabled threads disagree.
  always_comb begin
    diverged = 1'b0;
    for (int i = 0; i < THREADS; i++) begin
      if (thread_enable[i] && (next_pc[PC_BITS*i +: PC_BITS] != pc_sel)) diverged = 1'b1;
    end
  end

endmodule

// File: rtl/core_sequencer.sv
// Per-core control FSM: FETCH/DECODE/REQUEST/WAIT/EXECUTE/UPDATE, owns the shared PC.
// Six cycles per instruction minimum; all outputs registered.
// Stalls in FETCH on the fetcher and in WAIT on any enabled busy LSU during memory ops.
module core_sequencer
  import core_pkg::*;
#(
  parameter int THREADS = 4,
  parameter int PC_BITS = 8
) (
  input logic              clk,
  input logic              reset,
  core_sequencer_if.master bus
);

  core_state_e        state_q, state_d;
  logic [PC_BITS-1:0] current_pc_q, current_pc_d;
  logic               done_q, done_d;
  logic               divergence_q, divergence_d;
  logic [15:0]        instr_count_q, instr_count_d;

  logic [PC_BITS-1:0] pc_sel;
  logic               diverged;
  logic               any_lsu_busy;
  logic               mem_op;

  thread_pc_select #(
    .THREADS (THREADS),
    .PC_BITS (PC_BITS)
  ) u_pc_select (
    .thread_enable (bus.thread_enable),
    .next_pc       (bus.next_pc),
    .current_pc    (current_pc_q),
    .pc_sel        (pc_sel),
    .diverged      (diverged)
  );

  // Only enabled threads' LSUs can stall the core; disabled lanes may hold stale state.
  always_comb begin
    any_lsu_busy = 1'b0;
    for (int i = 0; i < THREADS; i++) begin
      if (bus.thread_enable[i] && lsu_busy(bus.lsu_state[2*i +: 2])) any_lsu_busy = 1'b1;
    end
  end

  assign mem_op = bus.decoded_mem_read_enable | bus.decoded_mem_write_enable;

  // Next-state and architectural updates; everything holds unless the state says otherwise.
  always_comb begin
    state_d        = state_q;
    current_pc_d   = current_pc_q;
    done_d         = done_q;
    divergence_d   = divergence_q;
    instr_count_d  = instr_count_q;
    unique case (state_q)
      ST_IDLE:    if (bus.start) state_d = ST_FETCH;
      ST_FETCH:   if (bus.fetcher_state == FETCHER_FETCHED) state_d = ST_DECODE;
      ST_DECODE:  state_d = ST_REQUEST;
      ST_REQUEST: state_d = ST_WAIT;
      ST_WAIT:    if (!mem_op || !any_lsu_busy) state_d = ST_EXECUTE;
      ST_EXECUTE: state_d = ST_UPDATE;
      ST_UPDATE: begin
        if (instr_count_q != INSTR_COUNT_MAX) instr_count_d = instr_count_q + 16'd1;
        if (diverged) divergence_d = 1'b1;
        if (bus.decoded_ret) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          state_d      = ST_FETCH;
          current_pc_d = pc_sel;
        end
      end
      ST_DONE:    state_d = ST_DONE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // State and status registers; synchronous reset abandons any in-flight instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      current_pc_q  <= '0;
      done_q        <= 1'b0;
      divergence_q  <= 1'b0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      current_pc_q  <= current_pc_d;
      done_q        <= done_d;
      divergence_q  <= divergence_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign bus.core_state  = state_q;
  assign bus.current_pc  = current_pc_q;
  assign bus.done        = done_q;
  assign bus.divergence  = divergence_q;
  assign bus.instr_count = instr_count_q;

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Per-core control FSM that drives the 3-bit `core_state` bus consumed by the fetcher, decoder, ALUs, LSUs and register files, and owns the core's shared program counter. It steps one instruction at a time through FETCH → DECODE → REQUEST → WAIT → EXECUTE → UPDATE. It stalls on the fetcher and on every enabled thread's LSU, advances the PC from the lowest enabled thread's `next_pc`, and flags divergent threads. It sits in the core between the dispatcher's start/done handshake and the per-thread datapath.

## Interface
- `THREADS`, 4, threads per core (1..16)
- `PC_BITS`, 8, program-counter width
- `clk`  in  1  core clock
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- `start`  in  1  launch the block; sampled in IDLE only
- `thread_enable`  in  THREADS  active-thread mask; stable while not IDLE
- `fetcher_state`  in  3  fetcher FSM state; FETCHED = 3'b010
- `decoded_mem_read_enable`  in  1  from decoder
- `decoded_mem_write_enable`  in  1  from decoder
- `decoded_ret`  in  1  from decoder
- `lsu_state`  in  2*THREADS  per-thread LSU state, thread i at [2i+1:2i]; IDLE 00, REQUESTING 01, WAITING 10, DONE 11
- `next_pc`  in  PC_BITS*THREADS  per-thread next PC, thread i at [PC_BITS*(i+1)-1:PC_BITS*i]
- `core_state`  out  3  IDLE 000, FETCH 001, DECODE 010, REQUEST 011, WAIT 100, EXECUTE 101, UPDATE 110, DONE 111
- `current_pc`  out  PC_BITS  PC of the instruction in flight
- `done`  out  1  block finished; held high until reset
- `divergence`  out  1  sticky; enabled threads disagreed on `next_pc`
- `instr_count`  out  16  retired instructions, saturating at 16'hFFFF

## Operation
- Reset (any state, any cycle):
  - `core_state` = IDLE.
  - `current_pc`, `done`, `divergence` and `instr_count` = 0.
  - In-flight work is abandoned.
- State transitions:
  - IDLE: `start` → FETCH. Otherwise stay.
  - FETCH: `fetcher_state` == 3'b010 → DECODE. Otherwise stay.
  - DECODE → REQUEST, unconditionally. This is exactly one cycle, which the decoder relies on.
  - REQUEST → WAIT, unconditionally.
  - WAIT:
    - If neither `decoded_mem_read_enable` nor `decoded_mem_write_enable` is set → EXECUTE.
    - Otherwise stay while any enabled thread's LSU is REQUESTING or WAITING, then → EXECUTE.
    - Disabled threads' `lsu_state` is ignored.
  - EXECUTE → UPDATE, unconditionally.
  - UPDATE with `decoded_ret`: → DONE and `done` ← 1. `current_pc` is unchanged and `instr_count` still increments.
  - UPDATE without `decoded_ret`:
    - `current_pc` ← `next_pc` of the lowest-index enabled thread.
    - `instr_count` += 1, saturating.
    - → FETCH.
  - DONE: hold until reset. `start` is ignored.
- PC source when `thread_enable` == 0: `current_pc` ← `current_pc` + 1, and WAIT exits after one cycle.
- PC arithmetic is modulo 2^PC_BITS: 8'hFF + 1 = 8'h00.
- Divergence: in UPDATE, if any two enabled threads present different `next_pc`, set `divergence` ← 1. It stays set until reset and execution continues on the selected PC.
- `start` asserted outside IDLE has no effect.

## Timing
- All outputs are registered and change only on the rising edge of `clk`.
- Minimum instruction period, when the fetch is ready on entry and there is no memory op:
  - FETCH 1 + DECODE 1 + REQUEST 1 + WAIT 1 + EXECUTE 1 + UPDATE 1 = 6 cycles.
- Memory instructions add one WAIT cycle per cycle that any enabled LSU is busy.
- `start` sampled high in IDLE at edge N gives `core_state` = FETCH after edge N.
- `done` rises on the same edge that `core_state` becomes DONE.
- `current_pc` changes only on the UPDATE → FETCH edge. It is stable from FETCH through UPDATE.

## Structure
- Shared package `core_pkg`:
  - Core state enum (8 encodings above).
  - `FETCHER_FETCHED` = 3'b010.
  - LSU state enum (IDLE/REQUESTING/WAITING/DONE).
  - `CORE_DECODE` = 3'b010, which must match the decoder's DECODE encoding.
- One sub-module, `thread_pc_select`:
  - Combinational priority pick of the lowest enabled thread's `next_pc`.
  - Enabled-mask equality compare producing the divergence flag.
  - `current_pc` + 1 fallback when no thread is enabled.

## Test plan
- Reset, then `start`, `fetcher_state` = 010 immediately, opcode ADD, mask 4'b1111, all `next_pc` = 1 → states 001,010,011,100,101,110,001; `current_pc` = 1 and `instr_count` = 1 after 6 cycles.
- LDR with threads 0–3 LSUs held WAITING for 5 cycles, thread 3 disabled and stuck WAITING → WAIT lasts 6 cycles; exits once threads 0–2 reach DONE.
- `decoded_ret` in UPDATE → `core_state` = 111 and `done` = 1 next cycle; `start` pulses afterwards change nothing; reset returns everything to 0 / IDLE.
- Mask 4'b1100, `next_pc` = {9,9,3,7} (thread 3..0) → `current_pc` = 9, `divergence` = 0; then {9,5,3,7} → `current_pc` = 5, `divergence` = 1 and sticky.
- `current_pc` = 8'hFF, mask 0 → `current_pc` = 8'h00 after UPDATE; `instr_count` preset near 16'hFFFF saturates.
- Reset asserted mid-WAIT with LSUs busy → IDLE and all outputs 0 on the next edge; fetch does not resume without `start`.
